// File: rtl/memory_dumper.sv
// -----------------------------------------------------------------------------
// memory_dumper
//   Streams a range of balanced-ternary memory words to a downstream consumer.
//   Each trit is 2 bits: TRIT_Z = 2'b00 (0), TRIT_P = 2'b01 (+1),
//   TRIT_N = 2'b10 (-1).
//   The address walks from start_addr to end_addr inclusive, incrementing in
//   ternary and wrapping silently at the top of the address space.
//   WORD_SIZE must be larger than MEM_ADDR_SIZE: the increment is done on the
//   address zero-padded to a full word.
//
// Ports
//   clock          : single clock, rising edge
//   reset          : asynchronous, active low
//   start_dump     : begin a dump (looked at only while idle)
//   abort          : cancel a dump in progress on the next edge
//   start_addr     : first address of the range (latched on start)
//   end_addr       : last address of the range (latched on start)
//   mem_addr       : memory read address
//   mem_read       : one-cycle read strobe; data is expected the cycle after
//   mem_read_data  : memory read data
//   out_data       : dumped word
//   out_valid      : out_data is valid
//   out_ready      : consumer accepts out_data
//   dump_busy      : high whenever the FSM is not idle
//   dump_complete  : one-cycle pulse at the normal end of a dump
//   word_count     : words accepted downstream in the current / last dump
//   o_state        : FSM state for observation
// -----------------------------------------------------------------------------
`ifndef TRIT_Z
`define TRIT_Z 2'b00
`endif
`ifndef TRIT_P
`define TRIT_P 2'b01
`endif
`ifndef TRIT_N
`define TRIT_N 2'b10
`endif

// Balanced-ternary ripple-carry adder: o_sum = i_a + i_b + i_carry.
module ternary_ripple_carry_adder #(
  parameter int N = 9
) (
  input  logic [2*N-1:0] i_a,
  input  logic [2*N-1:0] i_b,
  input  logic [1:0]     i_carry,
  output logic [2*N-1:0] o_sum,
  output logic [1:0]     o_carry
);

  function automatic logic signed [2:0] trit_val(input logic [1:0] t);
    case (t)
      `TRIT_P: trit_val = 3'sd1;
      `TRIT_N: trit_val = -3'sd1;
      default: trit_val = 3'sd0;
    endcase
  endfunction

  function automatic logic [1:0] trit_enc(input logic signed [2:0] v);
    case (v)
      3'sd1:   trit_enc = `TRIT_P;
      -3'sd1:  trit_enc = `TRIT_N;
      default: trit_enc = `TRIT_Z;
    endcase
  endfunction

  always_comb begin
    logic signed [2:0] s;
    logic signed [2:0] c;
    s     = 3'sd0;
    c     = trit_val(i_carry);
    o_sum = '0;
    for (int i = 0; i < N; i++) begin
      // Digit sum lies in -3..3; fold back into -1..1 with a carry of +/-1.
      s = trit_val(i_a[2*i +: 2]) + trit_val(i_b[2*i +: 2]) + c;
      if (s > 3'sd1) begin
        o_sum[2*i +: 2] = trit_enc(s - 3'sd3);
        c               = 3'sd1;
      end else if (s < -3'sd1) begin
        o_sum[2*i +: 2] = trit_enc(s + 3'sd3);
        c               = -3'sd1;
      end else begin
        o_sum[2*i +: 2] = trit_enc(s);
        c               = 3'sd0;
      end
    end
    o_carry = trit_enc(c);
  end

endmodule

module memory_dumper #(
  parameter int WORD_SIZE     = 9,
  parameter int MEM_ADDR_SIZE = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start_dump,
  input  logic                       abort,
  input  logic [2*MEM_ADDR_SIZE-1:0] start_addr,
  input  logic [2*MEM_ADDR_SIZE-1:0] end_addr,
  output logic [2*MEM_ADDR_SIZE-1:0] mem_addr,
  output logic                       mem_read,
  input  logic [2*WORD_SIZE-1:0]     mem_read_data,
  output logic [2*WORD_SIZE-1:0]     out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       dump_busy,
  output logic                       dump_complete,
  output logic [15:0]                word_count,
  output logic [2:0]                 o_state
);

  localparam int AW = 2 * MEM_ADDR_SIZE;
  localparam int DW = 2 * WORD_SIZE;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_end_addr;

  // Stream handshake: a word transfers on a rising edge where out_valid and
  // out_ready are both high. Once out_valid rises, out_data and out_valid are
  // held unchanged until that transfer; out_ready is don't-care while
  // out_valid is low.
  logic w_hs;
  assign w_hs = out_valid && out_ready;

  logic [DW-1:0] w_pad_addr;
  logic [DW-1:0] w_one;
  logic [DW-1:0] w_sum;
  logic [1:0]    w_unused_carry;
  logic [AW-1:0] w_next_addr;
  logic [DW-AW-1:0] w_unused_sum_hi;

  assign w_pad_addr = {{(DW-AW){1'b0}}, mem_addr};
  assign w_one      = {{(DW-2){1'b0}}, `TRIT_P};

  ternary_ripple_carry_adder #(.N(WORD_SIZE)) u_inc (
    .i_a     (w_pad_addr),
    .i_b     (w_one),
    .i_carry (`TRIT_Z),
    .o_sum   (w_sum),
    .o_carry (w_unused_carry)
  );

  // Truncation drops the carry out of the top address trit: silent wrap.
  assign w_next_addr     = w_sum[AW-1:0];
  assign w_unused_sum_hi = w_sum[DW-1:AW];

  assign dump_busy = (r_state != S_IDLE);
  assign o_state   = r_state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_end_addr    <= '0;
      mem_addr      <= '0;
      mem_read      <= 1'b0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      dump_complete <= 1'b0;
      word_count    <= 16'd0;
    end else begin
      dump_complete <= 1'b0;
      if (r_state != S_IDLE && abort) begin
        // Abort beats a simultaneous handshake, but the word did transfer.
        r_state   <= S_IDLE;
        out_valid <= 1'b0;
        mem_read  <= 1'b0;
        if (w_hs) word_count <= word_count + 16'd1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start_dump) begin
              mem_addr   <= start_addr;
              r_end_addr <= end_addr;
              word_count <= 16'd0;
              mem_read   <= 1'b1;
              r_state    <= S_READ;
            end
          end
          S_READ: begin
            mem_read <= 1'b0;
            r_state  <= S_WAIT;
          end
          S_WAIT: begin
            out_data  <= mem_read_data;
            out_valid <= 1'b1;
            r_state   <= S_SEND;
          end
          S_SEND: begin
            if (w_hs) begin
              out_valid  <= 1'b0;
              word_count <= word_count + 16'd1;
              if (mem_addr == r_end_addr) begin
                dump_complete <= 1'b1;
                r_state       <= S_DONE;
              end else begin
                mem_addr <= w_next_addr;
                mem_read <= 1'b1;
                r_state  <= S_READ;
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_memory_dumper.sv
// -----------------------------------------------------------------------------
// tb_memory_dumper
//   Directed and randomized dumps of a 3-trit address space (-13..13) whose
//   words are random and distinct. Expected words come from a reference model
//   that walks addresses as integers with modular wrap and converts to and
//   from balanced ternary arithmetically.
// -----------------------------------------------------------------------------
module tb_memory_dumper;

  localparam int WS    = 9;
  localparam int AS    = 3;
  localparam int DW    = 2 * WS;
  localparam int AW    = 2 * AS;
  localparam int NADDR = 27;
  localparam int HALF  = 13;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          start_dump = 1'b0;
  logic          abort      = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] end_addr   = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_read;
  logic [DW-1:0] mem_read_data = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          dump_busy;
  logic          dump_complete;
  logic [15:0]   word_count;
  logic [2:0]    o_state;

  memory_dumper #(.WORD_SIZE(WS), .MEM_ADDR_SIZE(AS)) dut (
    .clock         (clock),
    .reset         (reset),
    .start_dump    (start_dump),
    .abort         (abort),
    .start_addr    (start_addr),
    .end_addr      (end_addr),
    .mem_addr      (mem_addr),
    .mem_read      (mem_read),
    .mem_read_data (mem_read_data),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .dump_busy     (dump_busy),
    .dump_complete (dump_complete),
    .word_count    (word_count),
    .o_state       (o_state)
  );

  int checks   = 0;
  int failures = 0;
  int rd_count = 0;

  logic [DW-1:0] mem_words [NADDR];
  logic [DW-1:0] exp_q[$];
  int            exp_a[$];

  // ---- reference model helpers ----
  function automatic logic [AW-1:0] enc_addr(input int v);
    logic [AW-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < AS; i++) begin
      int m;
      m = ((x % 3) + 3) % 3;
      if (m == 1) begin
        r[2*i +: 2] = 2'b01;
        x = (x - 1) / 3;
      end else if (m == 2) begin
        r[2*i +: 2] = 2'b10;
        x = (x + 1) / 3;
      end else begin
        x = x / 3;
      end
    end
    return r;
  endfunction

  function automatic int dec_addr(input logic [AW-1:0] a);
    int v;
    int p;
    v = 0;
    p = 1;
    for (int i = 0; i < AS; i++) begin
      if (a[2*i +: 2] == 2'b01) v = v + p;
      else if (a[2*i +: 2] == 2'b10) v = v - p;
      p = p * 3;
    end
    return v;
  endfunction

  function automatic int wrap_addr(input int v);
    return (((v + HALF) % NADDR) + NADDR) % NADDR - HALF;
  endfunction

  // ---- memory model: data appears the cycle after the read strobe ----
  always @(posedge clock) begin
    if (mem_read) begin
      mem_read_data <= mem_words[dec_addr(mem_addr) + HALF];
      rd_count      <= rd_count + 1;
    end
  end

  // ---- scoreboard ----
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input int s, input int e);
    int a;
    exp_q.delete();
    exp_a.delete();
    a = s;
    for (int k = 0; k < NADDR; k++) begin
      exp_q.push_back(mem_words[a + HALF]);
      exp_a.push_back(a);
      if (a == e) break;
      a = wrap_addr(a + 1);
    end
  endtask

  // ---- driver tasks ----
  task automatic start(input int s, input int e);
    @(negedge clock);
    start_addr = enc_addr(s);
    end_addr   = enc_addr(e);
    start_dump = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start_dump = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_timeout"}, 32'(out_valid), 1);
  endtask

  // abort_idx: word index at which abort is raised (-1 none);
  // abort_hs: 1 = abort on the same edge as that word's handshake.
  task automatic do_dump(input int s, input int e, input int stall_idx,
                         input int stall_len, input int abort_idx, input int abort_hs);
    int n;
    int rd0;
    int a;
    logic [DW-1:0] d;
    build_exp(s, e);
    n         = exp_q.size();
    rd0       = rd_count;
    out_ready = 1'b1;
    start(s, e);
    chk("read_strobe", 32'(mem_read), 1);
    chk("busy_on_start", 32'(dump_busy), 1);
    chk("no_early_valid", 32'(out_valid), 0);
    @(negedge clock);
    chk("read_one_cycle", 32'(mem_read), 0);
    chk("no_early_valid2", 32'(out_valid), 0);
    @(negedge clock);
    chk("first_valid_latency", 32'(out_valid), 1);
    for (int i = 0; i < n; i++) begin
      wait_valid("word");
      d = exp_q.pop_front();
      a = exp_a.pop_front();
      chk("out_data", 32'(out_data), 32'(d));
      chk("mem_addr", 32'(mem_addr), 32'(enc_addr(a)));
      chk("count_before", 32'(word_count), i);
      if (i == abort_idx) begin
        out_ready = (abort_hs != 0);
        abort     = 1'b1;
        @(negedge clock);
        abort     = 1'b0;
        out_ready = 1'b1;
        chk("abort_idle", 32'(dump_busy), 0);
        chk("abort_valid", 32'(out_valid), 0);
        chk("abort_read", 32'(mem_read), 0);
        chk("abort_no_complete", 32'(dump_complete), 0);
        chk("abort_count", 32'(word_count), (abort_hs != 0) ? i + 1 : i);
        @(negedge clock);
        chk("abort_no_complete2", 32'(dump_complete), 0);
        chk("abort_count_hold", 32'(word_count), (abort_hs != 0) ? i + 1 : i);
        return;
      end
      if (i == stall_idx) begin
        out_ready = 1'b0;
        repeat (stall_len) begin
          @(negedge clock);
          chk("stall_valid", 32'(out_valid), 1);
          chk("stall_data", 32'(out_data), 32'(d));
        end
        chk("stall_no_read", rd_count - rd0, i + 1);
        out_ready = 1'b1;
      end
      @(negedge clock);
      chk("valid_drop", 32'(out_valid), 0);
    end
    chk("complete_pulse", 32'(dump_complete), 1);
    chk("final_count", 32'(word_count), n);
    @(negedge clock);
    chk("complete_one_cycle", 32'(dump_complete), 0);
    chk("idle_after_done", 32'(dump_busy), 0);
    chk("count_hold", 32'(word_count), n);
    chk("read_strobes", rd_count - rd0, n);
  endtask

  initial begin
    logic [31:0] r;
    int s;
    int len;
    for (int k = 0; k < NADDR; k++) begin
      r = $urandom;
      mem_words[k] = {r[17:5], 5'(k)};
    end

    // reset state
    repeat (2) @(negedge clock);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_complete", 32'(dump_complete), 0);
    chk("rst_word_count", 32'(word_count), 0);
    chk("rst_busy", 32'(dump_busy), 0);
    reset = 1'b1;
    @(negedge clock);

    do_dump(0, 3, -1, 0, -1, 0);      // basic 4-word dump
    do_dump(5, 5, -1, 0, -1, 0);      // single word
    do_dump(0, 3, 1, 10, -1, 0);      // back-pressure on second word
    do_dump(HALF, -HALF + 1, -1, 0, -1, 0); // top address wraps to bottom
    do_dump(-1, 1, -1, 0, -1, 0);     // passes through zero
    do_dump(0, 7, -1, 0, 2, 0);       // abort on third word
    do_dump(2, 4, -1, 0, -1, 0);      // restart after abort
    do_dump(3, 6, -1, 0, 1, 1);       // abort together with handshake

    repeat (4) begin
      s   = int'($urandom_range(0, NADDR - 1)) - HALF;
      len = int'($urandom_range(1, 6));
      do_dump(s, wrap_addr(s + len - 1), int'($urandom_range(0, len - 1)),
              int'($urandom_range(1, 4)), -1, 0);
    end

    // start_dump ignored mid-dump, then reset mid-SEND
    out_ready = 1'b1;
    start(0, 7);
    wait_valid("rst_w0");
    chk("rst_w0_data", 32'(out_data), 32'(mem_words[HALF]));
    out_ready  = 1'b0;
    start_addr = enc_addr(9);
    end_addr   = enc_addr(9);
    start_dump = 1'b1;
    @(negedge clock);
    start_dump = 1'b0;
    chk("ignore_start_addr", 32'(mem_addr), 32'(enc_addr(0)));
    chk("ignore_start_valid", 32'(out_valid), 1);
    chk("ignore_start_count", 32'(word_count), 0);
    out_ready = 1'b1;
    @(negedge clock);
    wait_valid("rst_w1");
    chk("rst_w1_addr", 32'(mem_addr), 32'(enc_addr(1)));
    chk("rst_w1_data", 32'(out_data), 32'(mem_words[HALF + 1]));
    #2 reset = 1'b0;
    #1;
    chk("async_mem_addr", 32'(mem_addr), 0);
    chk("async_mem_read", 32'(mem_read), 0);
    chk("async_out_data", 32'(out_data), 0);
    chk("async_out_valid", 32'(out_valid), 0);
    chk("async_complete", 32'(dump_complete), 0);
    chk("async_word_count", 32'(word_count), 0);
    chk("async_busy", 32'(dump_busy), 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("post_reset_idle", 32'(dump_busy), 0);
    chk("post_reset_complete", 32'(dump_complete), 0);
    do_dump(1, 2, -1, 0, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
